// File: rtl/neuraedge_accum_drain.sv
// Accumulator drain stage for a row of PEs.
// Snapshots all PE accumulators in one cycle and pulses a clear back to the row.
// Each snapshot element is requantized to a signed activation and streamed out
// on a valid/ready interface, one element per handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for i_drain_start; a start snapshots accum_in and cfg
// S_LOAD   | snapshot held; element 0 is requantized into the output register
// S_STREAM | presenting elements; advance on handshake, finish after last index
module neuraedge_accum_drain #(
  parameter int NUM_PE      = 32,
  parameter int ACCUM_WIDTH = 32,
  parameter int MULT_WIDTH  = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int IDX_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_drain_start,
  input  logic [NUM_PE*ACCUM_WIDTH-1:0] i_accum_in,
  input  logic signed [MULT_WIDTH-1:0]  i_cfg_mult,
  input  logic [4:0]                    i_cfg_shift,
  input  logic signed [OUT_WIDTH-1:0]   i_cfg_zero_point,
  input  logic                          i_cfg_relu,
  output logic                          o_mac_clear_out,
  output logic signed [OUT_WIDTH-1:0]   o_out_data,
  output logic [IDX_WIDTH-1:0]          o_out_index,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic                          o_out_last,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int PROD_W = ACCUM_WIDTH + MULT_WIDTH;
  // Two guard bits: one for the rounding bias, one for the zero-point add.
  localparam int EXT_W  = PROD_W + 2;
  localparam logic [IDX_WIDTH-1:0]    LAST_IDX = IDX_WIDTH'(NUM_PE - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX  = EXT_W'((1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ACCUM_WIDTH-1:0]       r_snap [NUM_PE];
  logic signed [MULT_WIDTH-1:0] r_mult;
  logic [4:0]                   r_shift;
  logic signed [OUT_WIDTH-1:0]  r_zp;
  logic                         r_relu;

  logic                         r_clear;
  logic                         r_valid;
  logic                         r_done;
  logic signed [OUT_WIDTH-1:0]  r_data;
  logic [IDX_WIDTH-1:0]         r_index;

  logic                         w_hs;
  logic                         w_snap_en;
  logic                         w_load;
  logic                         w_idx_clr;
  logic                         w_valid_nxt;
  logic                         w_done_nxt;
  logic                         w_clear_nxt;
  logic [IDX_WIDTH-1:0]         w_sel_idx;

  logic [ACCUM_WIDTH-1:0]       w_acc;
  logic signed [PROD_W-1:0]     w_acc_ext;
  logic signed [PROD_W-1:0]     w_mult_ext;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [EXT_W-1:0]      w_prod_x;
  logic signed [EXT_W-1:0]      w_bias;
  logic signed [EXT_W-1:0]      w_sum;
  logic signed [EXT_W-1:0]      w_rnd;
  logic signed [EXT_W-1:0]      w_relu;
  logic signed [EXT_W-1:0]      w_zp_ext;
  logic signed [EXT_W-1:0]      w_s;
  logic signed [OUT_WIDTH-1:0]  w_q;

  assign w_hs = r_valid & i_out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_snap_en   = 1'b0;
    w_load      = 1'b0;
    w_idx_clr   = 1'b0;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_clear_nxt = 1'b0;
    w_sel_idx   = '0;
    case (r_state)
      S_IDLE: begin
        if (i_drain_start) begin
          w_snap_en   = 1'b1;
          w_clear_nxt = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (w_hs) begin
          if (r_index == LAST_IDX) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_idx_clr   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load    = 1'b1;
            w_sel_idx = r_index + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot accumulators and requant config; contents are don't-care out of reset.
  always_ff @(posedge clk) begin
    if (w_snap_en) begin
      for (int i = 0; i < NUM_PE; i++) begin
        r_snap[i] <= i_accum_in[i*ACCUM_WIDTH +: ACCUM_WIDTH];
      end
      r_mult  <= i_cfg_mult;
      r_shift <= i_cfg_shift;
      r_zp    <= i_cfg_zero_point;
      r_relu  <= i_cfg_relu;
    end
  end

  // Requant of the element about to be loaded: multiply, round-half-up shift,
  // optional ReLU, zero-point add, saturate. Widths are chosen so nothing overflows.
  assign w_acc      = r_snap[w_sel_idx];
  assign w_acc_ext  = {{MULT_WIDTH{w_acc[ACCUM_WIDTH-1]}}, w_acc};
  assign w_mult_ext = {{ACCUM_WIDTH{r_mult[MULT_WIDTH-1]}}, r_mult};
  assign w_prod     = w_acc_ext * w_mult_ext;
  assign w_prod_x   = {{2{w_prod[PROD_W-1]}}, w_prod};
  assign w_bias     = (r_shift == 5'd0) ? '0 : (EXT_W'(1) << (r_shift - 5'd1));
  assign w_sum      = w_prod_x + w_bias;
  assign w_rnd      = w_sum >>> r_shift;
  assign w_relu     = (r_relu && w_rnd[EXT_W-1]) ? '0 : w_rnd;
  assign w_zp_ext   = {{(EXT_W-OUT_WIDTH){r_zp[OUT_WIDTH-1]}}, r_zp};
  assign w_s        = w_relu + w_zp_ext;
  assign w_q        = (w_s > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] :
                      (w_s < SAT_MIN) ? SAT_MIN[OUT_WIDTH-1:0] :
                      w_s[OUT_WIDTH-1:0];

  // Output registers; data and index only move on a load so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clear <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
    end else begin
      r_clear <= w_clear_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_data  <= w_q;
        r_index <= w_sel_idx;
      end else if (w_idx_clr) begin
        r_index <= '0;
      end
    end
  end

  assign o_mac_clear_out = r_clear;
  assign o_out_data      = r_data;
  assign o_out_index     = r_index;
  assign o_out_valid     = r_valid;
  assign o_out_last      = r_valid & (r_index == LAST_IDX);
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = r_done;

endmodule

// File: doc/neuraedge_accum_drain.md
Name: neuraedge_accum_drain

Overview:
Downstream stage of a row of NUM_PE processing elements. On command it snapshots every PE accumulator in one cycle and issues a one-cycle clear back to the PEs. It then requantizes each 32-bit accumulator to a signed 8-bit activation (multiply, rounding shift, ReLU, zero-point, saturate) and streams the results out one per handshake to the activation write-back path.

Parameters:
NUM_PE, 32, number of PE accumulators drained per command
ACCUM_WIDTH, 32, signed accumulator width per PE
MULT_WIDTH, 16, signed requant multiplier width
OUT_WIDTH, 8, signed output activation width
IDX_WIDTH, 5, width of element index; must satisfy 2**IDX_WIDTH >= NUM_PE

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
drain_start  input  1  request to snapshot and stream; sampled only in IDLE
accum_in  input  NUM_PE*ACCUM_WIDTH  packed PE accumulators; PE i at bits [i*ACCUM_WIDTH +: ACCUM_WIDTH]
cfg_mult  input  MULT_WIDTH  signed requant multiplier
cfg_shift  input  5  right-shift amount, 0..31
cfg_zero_point  input  OUT_WIDTH  signed output zero point
cfg_relu  input  1  1 = clamp negatives to 0 before zero-point add
mac_clear_out  output  1  one-cycle clear pulse to the PE row
out_data  output  OUT_WIDTH  signed requantized activation
out_index  output  IDX_WIDTH  PE index of out_data
out_valid  output  1  out_data/out_index/out_last valid
out_ready  input  1  consumer accepts when high with out_valid
out_last  output  1  high with the element at index NUM_PE-1
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (async, any time, including mid-stream): state=IDLE; mac_clear_out, out_valid, out_last, busy, done = 0; out_data, out_index = 0; snapshot contents are don't-care and discarded.
- States: IDLE, LOAD, STREAM.
- IDLE: if drain_start=1 at edge k:
  - snapshot accum_in into NUM_PE registers;
  - latch cfg_mult, cfg_shift, cfg_zero_point, cfg_relu (cfg changes after edge k have no effect on this drain);
  - mac_clear_out=1 for exactly the cycle after edge k;
  - busy=1; go to LOAD.
- LOAD: at edge k+1, load output register with element 0; out_valid=1, out_index=0; go to STREAM. First out_valid is 1 cycle after the drain_start edge.
- STREAM:
  - Handshake = out_valid & out_ready at an edge.
  - No handshake: out_data, out_index, out_last held stable.
  - Handshake on index j < NUM_PE-1: load element j+1 at the same edge, so back-to-back accepts give one element per cycle.
  - Handshake on index NUM_PE-1: out_valid=0, out_last=0, busy=0, done=1 for one cycle; go to IDLE.
  - A new drain_start may be accepted in the cycle done is high.
- out_last = out_valid & (out_index == NUM_PE-1).
- drain_start while busy is ignored; it is not queued.
- Requant per element, all signed, no intermediate overflow:
  - p = acc * cfg_mult, ACCUM_WIDTH+MULT_WIDTH bits.
  - if cfg_shift>0: r = (p + (1 << (cfg_shift-1))) >>> cfg_shift; else r = p. This is round-half-up with an arithmetic shift.
  - if cfg_relu and r<0: r = 0.
  - s = r + sign-extended cfg_zero_point.
  - out_data = saturate(s) to [-(2**(OUT_WIDTH-1)), 2**(OUT_WIDTH-1)-1].
- Requant is combinational from the snapshot element selected by the next index. The result is registered into out_data, so the output is glitch-free and stable under backpressure.
- accum_in may change freely after the snapshot edge; only the snapshot is used.

Test Plan:
- Reset/idle: rst_n asserted mid-STREAM at index 7 -> out_valid, busy, done, mac_clear_out go 0 immediately. After release with no drain_start, all outputs stay 0.
- Basic drain: mult=1, shift=0, zp=0, relu=0; PE0=100, PE1=300, PE2=-300, others=i; out_ready=1 -> mac_clear_out single pulse 1 cycle after start. out_valid from the next cycle with data 100, 127, -128, 3, 4, ... 31. out_last at index 31, done pulse the cycle after, 33 cycles total from start to done.
- Rounding: shift=1, mult=1; PE0=5, PE1=-5, PE2=4 -> out_data 3, -2, 2. Also mult=3, shift=4, PE0=1000 -> 188 saturates to 127.
- ReLU/zero point: relu=1, zp=10; PE0=-50, PE1=20 -> 10, 30. With relu=0, zp=-20, PE0=-120 -> -128.
- Backpressure: out_ready toggled randomly, held low 5 cycles at index 4 -> out_data/out_index stable while low. Every index 0..31 delivered exactly once, in order.
- Ignored/overlapping commands: drain_start pulsed during STREAM -> no second snapshot and no mac_clear_out. drain_start asserted in the done cycle -> new drain starts, mac_clear_out pulses the next cycle. cfg_mult changed mid-stream -> no effect on current outputs.
